// File: rtl/ad7352_capture_pkg.sv
// Shared definitions for the AD7352 dual-ADC capture block.
// Contents: FSM state type, sample width, serial bit-window bounds,
// and channel indices used to map serial lines onto capture lanes.
package ad7352_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned ADC_BITS = 12;

  // Frame counter values that carry data bits (MSB first).
  localparam int unsigned FIRST_BIT_CNT = 2;
  localparam int unsigned LAST_BIT_CNT  = 13;

  // Channel indices into the per-lane serial input vector.
  localparam int unsigned VCAP = 0;
  localparam int unsigned ICAP = 1;
  localparam int unsigned VOUT = 2;
  localparam int unsigned IOUT = 3;

endpackage

// File: rtl/ad7352_capture_if.sv
// Pin-level bus between the capture controller and the AD7352 pair.
//   ad_cs      : shared chip select, active low (driven by master)
//   ad_sdata_a : converter A lines, [1]=vout, [0]=iout
//   ad_sdata_b : converter B lines, [1]=vcap, [0]=icap
// master = capture controller, slave = ADC (or its model).
interface ad7352_capture_if;
  logic       ad_cs;
  logic [1:0] ad_sdata_a;
  logic [1:0] ad_sdata_b;

  modport master (
    output ad_cs,
    input  ad_sdata_a,
    input  ad_sdata_b
  );

  modport slave (
    input  ad_cs,
    output ad_sdata_a,
    output ad_sdata_b
  );
endinterface

// File: rtl/ad7352_capture_lane.sv
// One capture lane: MSB-first shift register with a parallel output
// register that only changes on load.
//   clk, reset : clock, synchronous active-high reset
//   shift_en_i : shift din_i into the register this cycle
//   load_i     : update dout_o this cycle
//   din_i      : serial data bit
//   dout_o     : last loaded sample
module ad7352_lane
  import ad7352_pkg::*;
#(
  parameter int unsigned W = ADC_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en_i,
  input  logic         load_i,
  input  logic         din_i,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;
  logic [W-1:0] out_q;

  // Load takes the value including the bit arriving this cycle, so the
  // final bit and the output update land on the same edge.
  assign sr_d = {sr_q[W-2:0], din_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      out_q <= '0;
    end else begin
      if (shift_en_i) sr_q  <= sr_d;
      if (load_i)     out_q <= sr_d;
    end
  end

  assign dout_o = out_q;

endmodule

// File: rtl/ad7352_capture.sv
// Serial capture controller for the dual AD7352 ADC pair.
// Drives the shared chip select, shifts in four 12-bit channels MSB
// first (SCLK = clk, data launched by the ADC on the falling edge,
// sampled here on the rising edge) and presents them as a parallel
// sample with a one-cycle valid strobe.
//   clk, reset : system clock, synchronous active-high reset
//   start      : request one conversion (ignored when FREE_RUN=1)
//   adc        : ADC pin bus (chip select out, four serial lines in)
//   busy       : high while a frame or its CS-high gap is in progress
//   valid      : one-cycle strobe, samples updated in the same cycle
//   vcap/icap/vout/iout : last captured samples, straight binary
//   missed     : one-cycle pulse for each start seen while busy
module ad7352_capture
  import ad7352_pkg::*;
#(
  parameter int unsigned CS_LOW_CYCLES  = 16,
  parameter int unsigned CS_HIGH_CYCLES = 2,
  parameter int unsigned FREE_RUN       = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  ad7352_capture_if.master    adc,
  output logic                busy,
  output logic                valid,
  output logic [ADC_BITS-1:0] vcap,
  output logic [ADC_BITS-1:0] icap,
  output logic [ADC_BITS-1:0] vout,
  output logic [ADC_BITS-1:0] iout,
  output logic                missed
);

  localparam int unsigned CNT_W = $clog2(CS_LOW_CYCLES + CS_HIGH_CYCLES);
  localparam logic        AUTO  = (FREE_RUN != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             cs_q;
  logic             valid_q;
  logic             missed_q;
  logic             start_eff;
  logic             shift_en;
  logic             load;
  logic [3:0]       din;

  assign start_eff = start & ~AUTO;
  assign busy      = (state_q != IDLE);

  // Data lines are X while CS is high; shifting is confined to the bit
  // window so nothing outside it can reach the lanes.
  assign shift_en = (state_q == CONV) &&
                    (cnt_q >= CNT_W'(FIRST_BIT_CNT)) &&
                    (cnt_q <= CNT_W'(LAST_BIT_CNT));
  assign load     = (state_q == CONV) && (cnt_q == CNT_W'(LAST_BIT_CNT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    pend_d  = pend_q;

    if (start_eff && busy) pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (AUTO || start_eff) state_d = CONV;
      end
      CONV: begin
        if (cnt_q == CNT_W'(CS_LOW_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_HIGH_CYCLES - 1)) begin
          cnt_d = '0;
          // A start landing in the last gap cycle is folded into the
          // pending request so the next frame follows without IDLE.
          if (AUTO || pend_q || start_eff) begin
            state_d = CONV;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      cs_q     <= 1'b1;
      valid_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      cs_q     <= (state_d != CONV);
      valid_q  <= load;
      missed_q <= start_eff & busy;
    end
  end

  assign adc.ad_cs = cs_q;
  assign valid     = valid_q;
  assign missed    = missed_q;

  assign din[VCAP] = adc.ad_sdata_b[1];
  assign din[ICAP] = adc.ad_sdata_b[0];
  assign din[VOUT] = adc.ad_sdata_a[1];
  assign din[IOUT] = adc.ad_sdata_a[0];

  ad7352_lane #(.W(ADC_BITS)) u_lane_vcap (
    .clk(clk), .reset(reset), .shift_en_i(shift_en), .load_i(load),
    .din_i(din[VCAP]), .dout_o(vcap)
  );

  ad7352_lane #(.W(ADC_BITS)) u_lane_icap (
    .clk(clk), .reset(reset), .shift_en_i(shift_en), .load_i(load),
    .din_i(din[ICAP]), .dout_o(icap)
  );

  ad7352_lane #(.W(ADC_BITS)) u_lane_vout (
    .clk(clk), .reset(reset), .shift_en_i(shift_en), .load_i(load),
    .din_i(din[VOUT]), .dout_o(vout)
  );

  ad7352_lane #(.W(ADC_BITS)) u_lane_iout (
    .clk(clk), .reset(reset), .shift_en_i(shift_en), .load_i(load),
    .din_i(din[IOUT]), .dout_o(iout)
  );

endmodule
